// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler
// Four-buffer frame scheduler between the video input writer and the
// display/rotation reader in front of the DDR frame store. Tracks each
// buffer's ownership and hands out write/read buffer indices and base
// addresses on frame-start requests. The reader always gets the newest
// completed frame. Frames the reader never picks up are dropped, and
// reader frames with nothing new are repeats. Both are counted.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   wr_frame_start writer frame-start pulse (buffer request)
//   wr_frame_done  writer frame-complete pulse
//   rd_frame_start reader frame-start pulse (buffer request)
//   wr_grant       pulse: wr_index / wr_base_addr updated
//   wr_index       buffer being written
//   wr_base_addr   BASE_ADDR + wr_index*FRAME_BYTES
//   rd_grant       pulse: reader request serviced
//   rd_new         with rd_grant: 1 = fresh frame, 0 = repeat
//   rd_valid       a completed frame has been issued to the reader
//   rd_index       buffer being read
//   rd_base_addr   BASE_ADDR + rd_index*FRAME_BYTES
//   drop_cnt       completed frames discarded unread (saturating)
//   repeat_cnt     reader frames serviced with a repeated buffer (saturating)
//
// Buffer states
//   state      | meaning
//   B_FREE     | not owned, available to the writer
//   B_WRITING  | owned by the writer (at most one)
//   B_READY    | newest completed frame, not yet read (at most one)
//   B_READING  | owned by the reader (at most one)

module frame_buf_scheduler #(
   parameter int                 ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0]  FRAME_BYTES = 32'h0020_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_frame_start,
   input  logic              wr_frame_done,
   input  logic              rd_frame_start,
   output logic              wr_grant,
   output logic [1:0]        wr_index,
   output logic [ADDR_W-1:0] wr_base_addr,
   output logic              rd_grant,
   output logic              rd_new,
   output logic              rd_valid,
   output logic [1:0]        rd_index,
   output logic [ADDR_W-1:0] rd_base_addr,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       repeat_cnt
);

   typedef enum logic [1:0] {
      B_FREE    = 2'd0,
      B_WRITING = 2'd1,
      B_READY   = 2'd2,
      B_READING = 2'd3
   } buf_st_t;

   buf_st_t     st_q [4];
   buf_st_t     st_d [4];

   logic        wr_grant_d;
   logic [1:0]  wr_index_d;
   logic        rd_grant_d;
   logic        rd_new_d;
   logic        rd_valid_d;
   logic [1:0]  rd_index_d;
   logic        drop_inc;
   logic        rep_inc;

   // {found, index} of the lowest-index buffer in state t
   logic [2:0]  hit_wr_done;
   logic [2:0]  hit_rdy_done;
   logic [2:0]  hit_wr_start;
   logic [2:0]  hit_free_start;
   logic [2:0]  hit_rdy_rd;
   logic [2:0]  hit_rding_rd;

   function automatic logic [2:0] find_st(input buf_st_t s [4], input buf_st_t t);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (s[i] == t) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
      return BASE_ADDR + FRAME_BYTES * ADDR_W'(idx);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) st_q[i] <= B_FREE;
         wr_grant     <= 1'b0;
         wr_index     <= 2'd0;
         wr_base_addr <= BASE_ADDR;
         rd_grant     <= 1'b0;
         rd_new       <= 1'b0;
         rd_valid     <= 1'b0;
         rd_index     <= 2'd0;
         rd_base_addr <= BASE_ADDR;
         drop_cnt     <= 16'd0;
         repeat_cnt   <= 16'd0;
      end else begin
         for (int i = 0; i < 4; i++) st_q[i] <= st_d[i];
         wr_grant     <= wr_grant_d;
         wr_index     <= wr_index_d;
         wr_base_addr <= base_of(wr_index_d);
         rd_grant     <= rd_grant_d;
         rd_new       <= rd_new_d;
         rd_valid     <= rd_valid_d;
         rd_index     <= rd_index_d;
         rd_base_addr <= base_of(rd_index_d);
         if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (rep_inc && repeat_cnt != 16'hFFFF) repeat_cnt <= repeat_cnt + 16'd1;
      end
   end

   // Events resolve in order done -> write start -> read start, each stage
   // seeing the buffer states left by the previous one.
   always_comb begin
      for (int i = 0; i < 4; i++) st_d[i] = st_q[i];
      wr_grant_d     = 1'b0;
      wr_index_d     = wr_index;
      rd_grant_d     = 1'b0;
      rd_new_d       = 1'b0;
      rd_valid_d     = rd_valid;
      rd_index_d     = rd_index;
      drop_inc       = 1'b0;
      rep_inc        = 1'b0;
      hit_wr_done    = 3'b000;
      hit_rdy_done   = 3'b000;
      hit_wr_start   = 3'b000;
      hit_free_start = 3'b000;
      hit_rdy_rd     = 3'b000;
      hit_rding_rd   = 3'b000;

      if (wr_frame_done) begin
         hit_wr_done  = find_st(st_d, B_WRITING);
         hit_rdy_done = find_st(st_d, B_READY);
         if (hit_wr_done[2]) begin
            if (hit_rdy_done[2]) begin
               st_d[hit_rdy_done[1:0]] = B_FREE;
               drop_inc = 1'b1;
            end
            st_d[hit_wr_done[1:0]] = B_READY;
         end
      end

      if (wr_frame_start) begin
         hit_wr_start   = find_st(st_d, B_WRITING);
         hit_free_start = find_st(st_d, B_FREE);
         wr_grant_d     = 1'b1;
         // A restart while writing abandons the partial frame in place.
         if (!hit_wr_start[2]) begin
            st_d[hit_free_start[1:0]] = B_WRITING;
            wr_index_d = hit_free_start[1:0];
         end
      end

      if (rd_frame_start) begin
         hit_rdy_rd   = find_st(st_d, B_READY);
         hit_rding_rd = find_st(st_d, B_READING);
         if (hit_rdy_rd[2]) begin
            if (hit_rding_rd[2]) st_d[hit_rding_rd[1:0]] = B_FREE;
            st_d[hit_rdy_rd[1:0]] = B_READING;
            rd_index_d = hit_rdy_rd[1:0];
            rd_grant_d = 1'b1;
            rd_new_d   = 1'b1;
            rd_valid_d = 1'b1;
         end else if (rd_valid) begin
            rd_grant_d = 1'b1;
            rep_inc    = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_buf_scheduler.sv
module tb_frame_buf_scheduler;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] FB   = 32'h0020_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_frame_start = 1'b0;
   logic        wr_frame_done  = 1'b0;
   logic        rd_frame_start = 1'b0;
   logic        wr_grant;
   logic [1:0]  wr_index;
   logic [31:0] wr_base_addr;
   logic        rd_grant;
   logic        rd_new;
   logic        rd_valid;
   logic [1:0]  rd_index;
   logic [31:0] rd_base_addr;
   logic [15:0] drop_cnt;
   logic [15:0] repeat_cnt;

   int checks = 0;
   int errors = 0;

   frame_buf_scheduler #(.ADDR_W(32), .BASE_ADDR(BASE), .FRAME_BYTES(FB)) dut (
      .clk(clk), .rst(rst),
      .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
      .rd_frame_start(rd_frame_start),
      .wr_grant(wr_grant), .wr_index(wr_index), .wr_base_addr(wr_base_addr),
      .rd_grant(rd_grant), .rd_new(rd_new), .rd_valid(rd_valid),
      .rd_index(rd_index), .rd_base_addr(rd_base_addr),
      .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
   );

   always #5 clk = ~clk;

   // Model: tracks which buffer plays each role (-1 = none).
   int m_writing, m_ready, m_reading;
   int e_wi, e_ri, e_drop, e_rep;
   bit e_wg, e_rg, e_rn, e_rv;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit wd, input bit ws, input bit rs);
      if (!r) begin
         m_writing = -1; m_ready = -1; m_reading = -1;
         e_wi = 0; e_ri = 0; e_drop = 0; e_rep = 0;
         e_wg = 0; e_rg = 0; e_rn = 0; e_rv = 0;
         return;
      end
      e_wg = 0; e_rg = 0; e_rn = 0;
      if (wd && m_writing >= 0) begin
         if (m_ready >= 0 && e_drop < 65535) e_drop++;
         m_ready = m_writing;
         m_writing = -1;
      end
      if (ws) begin
         e_wg = 1;
         if (m_writing < 0) begin
            for (int i = 3; i >= 0; i--)
               if (i != m_ready && i != m_reading) m_writing = i;
            e_wi = m_writing;
         end
      end
      if (rs) begin
         if (m_ready >= 0) begin
            m_reading = m_ready;
            m_ready = -1;
            e_ri = m_reading;
            e_rg = 1; e_rn = 1; e_rv = 1;
         end else if (e_rv) begin
            e_rg = 1;
            if (e_rep < 65535) e_rep++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_grant", 32'(wr_grant), 32'(e_wg));
         chk("wr_index", 32'(wr_index), 32'(e_wi));
         chk("wr_base_addr", wr_base_addr, BASE + FB * 32'(e_wi));
         chk("rd_grant", 32'(rd_grant), 32'(e_rg));
         chk("rd_new", 32'(rd_new), 32'(e_rn));
         chk("rd_valid", 32'(rd_valid), 32'(e_rv));
         chk("rd_index", 32'(rd_index), 32'(e_ri));
         chk("rd_base_addr", rd_base_addr, BASE + FB * 32'(e_ri));
         chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
         chk("repeat_cnt", 32'(repeat_cnt), 32'(e_rep));
      end
   end

   task automatic cyc(input bit r, input bit wd, input bit ws, input bit rs);
      rst = r; wr_frame_done = wd; wr_frame_start = ws; rd_frame_start = rs;
      @(posedge clk);
      model_step(r, wd, ws, rs);
      chk_en = 1'b1;
      @(negedge clk);
      #1;
   endtask

   initial begin
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 1);
      chk("lit_rst_wr_index", 32'(wr_index), 32'd0);
      chk("lit_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("lit_rst_base", wr_base_addr, 32'h8000_0000);

      // Reader asks before any frame exists.
      cyc(1, 0, 0, 1);
      chk("lit_early_rd_grant", 32'(rd_grant), 32'd0);
      chk("lit_early_repeat", 32'(repeat_cnt), 32'd0);

      // First frame through buffer 0, then a repeat.
      cyc(1, 0, 1, 0);
      chk("lit_first_wr_grant", 32'(wr_grant), 32'd1);
      chk("lit_first_wr_index", 32'(wr_index), 32'd0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 1);
      chk("lit_first_rd_new", 32'(rd_new), 32'd1);
      chk("lit_first_rd_index", 32'(rd_index), 32'd0);
      cyc(1, 0, 0, 1);
      chk("lit_repeat_rd_new", 32'(rd_new), 32'd0);
      chk("lit_repeat_cnt", 32'(repeat_cnt), 32'd1);

      // Drop: writer completes bufs 1 and 2 with no read in between.
      cyc(1, 0, 1, 0);
      chk("lit_drop_wr1", 32'(wr_index), 32'd1);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 1, 0);
      chk("lit_drop_wr2", 32'(wr_index), 32'd2);
      cyc(1, 1, 0, 0);
      chk("lit_drop_cnt1", 32'(drop_cnt), 32'd1);
      cyc(1, 0, 0, 1);
      chk("lit_drop_rd2", 32'(rd_index), 32'd2);
      cyc(1, 0, 1, 0);
      chk("lit_drop_wr0", 32'(wr_index), 32'd0);

      // Get the writer onto buffer 1, then all three events together.
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 1, 0);
      chk("lit_same_pre_wr1", 32'(wr_index), 32'd1);
      cyc(1, 1, 1, 1);
      chk("lit_same_rd_index", 32'(rd_index), 32'd1);
      chk("lit_same_rd_new", 32'(rd_new), 32'd1);
      chk("lit_same_wr_index", 32'(wr_index), 32'd2);
      chk("lit_same_wr_base", wr_base_addr, 32'h8040_0000);

      // Restart while writing keeps the same buffer.
      cyc(1, 0, 1, 0);
      chk("lit_restart1", 32'(wr_index), 32'd2);
      cyc(1, 0, 1, 0);
      chk("lit_restart2_grant", 32'(wr_grant), 32'd1);
      chk("lit_restart2_index", 32'(wr_index), 32'd2);
      cyc(1, 0, 0, 0);
      chk("lit_idle_wr_grant", 32'(wr_grant), 32'd0);

      // Forced drops up to saturation.
      for (int n = 0; n < 70000; n++) cyc(1, 1, 1, 0);
      chk("lit_drop_sat", 32'(drop_cnt), 32'h0000_FFFF);

      // Reset mid-write with a done pulse in the same cycle.
      cyc(0, 1, 0, 0);
      chk("lit_midrst_drop", 32'(drop_cnt), 32'd0);
      chk("lit_midrst_rd_valid", 32'(rd_valid), 32'd0);
      chk("lit_midrst_wr_index", 32'(wr_index), 32'd0);
      cyc(1, 0, 0, 1);
      chk("lit_post_rst_rd_grant", 32'(rd_grant), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
